// File: rtl/display_mux32.sv
`default_nettype none
// ============================================================================
// Module   : display_mux32
// Purpose  : 8-digit time-multiplexed common-anode hex display driver with
//            per-frame snapshot of the input and optional leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module display_mux32 #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic        blank_lz,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        frame_start
);

    localparam int             CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q;
    logic [2:0]       idx_q;
    logic [31:0]      shadow_q;
    logic             frame_start_q;

    // The snapshot is only replaced on the last dwell edge of digit 7, so a
    // whole scan always shows one coherent value.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q     <= '0;
            idx_q         <= 3'd0;
            shadow_q      <= 32'd0;
            frame_start_q <= 1'b0;
        end else if (div_cnt_q == CNT_MAX) begin
            div_cnt_q <= '0;
            idx_q     <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
                shadow_q      <= value;
                frame_start_q <= 1'b1;
            end else begin
                frame_start_q <= 1'b0;
            end
        end else begin
            div_cnt_q     <= div_cnt_q + CNT_W'(1);
            frame_start_q <= 1'b0;
        end
    end

    logic [31:0] w_shifted;
    logic        w_blank;
    logic [3:0]  w_nibble;
    logic [6:0]  w_hex;

    // Shifting the current digit down to bit 0 makes "this and all higher
    // nibbles are zero" a simple compare against zero.
    assign w_shifted = shadow_q >> {idx_q, 2'b00};
    assign w_nibble  = w_shifted[3:0];
    assign w_blank   = blank_lz && (idx_q != 3'd0) && (w_shifted == 32'd0);

    always_comb begin
        w_hex = 7'h7F;
        case (w_nibble)
            4'h0: w_hex = 7'h40;
            4'h1: w_hex = 7'h79;
            4'h2: w_hex = 7'h24;
            4'h3: w_hex = 7'h30;
            4'h4: w_hex = 7'h19;
            4'h5: w_hex = 7'h12;
            4'h6: w_hex = 7'h02;
            4'h7: w_hex = 7'h78;
            4'h8: w_hex = 7'h00;
            4'h9: w_hex = 7'h10;
            4'hA: w_hex = 7'h08;
            4'hB: w_hex = 7'h03;
            4'hC: w_hex = 7'h46;
            4'hD: w_hex = 7'h21;
            4'hE: w_hex = 7'h06;
            4'hF: w_hex = 7'h0E;
            default: w_hex = 7'h7F;
        endcase
    end

    assign an          = w_blank ? 8'hFF : ~(8'b1 << idx_q);
    assign seg         = w_blank ? 7'h7F : w_hex;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_display_mux32.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_mux32
// Purpose  : Randomized self-checking bench for display_mux32 against a
//            cycle-count based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_mux32;

    localparam int DIV   = 4;
    localparam int FRAME = 8 * DIV;

    logic        clk;
    logic        reset;
    logic [31:0] value;
    logic        blank_lz;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        frame_start;

    display_mux32 #(.REFRESH_DIV(DIV)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .blank_lz    (blank_lz),
        .an          (an),
        .seg         (seg),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // Model state: edges since reset released, current snapshot, pulse flag.
    int          m_t;
    logic [31:0] m_snap;
    logic        m_fs;
    logic [6:0]  hex_tab [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, m_t, got, exp);
        end
    endtask

    task automatic check_outputs();
        int          d;
        logic [31:0] upper;
        logic        blank;
        logic [7:0]  exp_an;
        logic [6:0]  exp_seg;
        d      = (m_t / DIV) % 8;
        upper  = m_snap >> (4 * d);
        blank  = blank_lz && (d != 0) && (upper == 32'd0);
        exp_an = blank ? 8'hFF : ~(8'(1) << d);
        exp_seg = blank ? 7'h7F : hex_tab[upper[3:0]];
        chk("an", {24'd0, an}, {24'd0, exp_an});
        chk("seg", {25'd0, seg}, {25'd0, exp_seg});
        chk("frame_start", {31'd0, frame_start}, {31'd0, m_fs});
    endtask

    // Inputs must be stable when called; the model consumes them at the edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_t    = 0;
            m_snap = 32'd0;
            m_fs   = 1'b0;
        end else begin
            m_t++;
            m_fs = (m_t % FRAME == 0);
            if (m_fs) m_snap = value;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        n_cmp = 0;
        n_err = 0;
        m_t = 0; m_snap = 0; m_fs = 0;

        // Reset with a nonzero value present; display must stay at zero.
        reset = 1'b1; value = 32'hDEADBEEF; blank_lz = 1'b0;
        run(3);
        chk("rst_an", {24'd0, an}, 32'h0000_00FE);
        chk("rst_seg", {25'd0, seg}, 32'h0000_0040);
        reset = 1'b0;
        run(FRAME - 1);
        chk("pre_latch_seg", {25'd0, seg}, 32'h0000_0040);

        // Plain scan of a known value over two frames.
        value = 32'h01234567;
        run(2 * FRAME + 1);

        // Tear-free: change the value while digit 3 is lit.
        while ((m_t / DIV) % 8 != 3) tick();
        value = 32'hFFFFFFFF;
        run(2 * FRAME);

        // Leading-zero blanking, then all-zero value.
        blank_lz = 1'b1; value = 32'h000000A5;
        run(2 * FRAME);
        value = 32'd0;
        run(2 * FRAME);

        // Blanking switched off combinationally in the middle of a frame.
        while ((m_t / DIV) % 8 != 4) tick();
        blank_lz = 1'b0;
        #1 check_outputs();
        run(FRAME);

        // Reset mid-frame at idx=5, div_cnt=2.
        value = 32'h89ABCDEF;
        run(FRAME);
        for (int i = 0; i < FRAME && (m_t % FRAME) != 5 * DIV + 2; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run(2 * FRAME + 2);

        // Randomized: values with varying leading zeros, blank toggles, rare resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) value = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 40) == 0) blank_lz = ~blank_lz;
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
